// File: rtl/gp_rf_pkg.sv
// Shared constants and helpers for the multi-port general register file.
package gp_rf_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int RF_DEPTH = 2 ** AW_DEF;
  localparam logic [31:0] ZERO_ADDR = 32'd0;

  // With a hardwired r0, address 0 never accepts writes or busy marks.
  function automatic logic writable(input logic [31:0] addr, input logic zero_r0);
    return !(zero_r0 && (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/gp_rf_rdport.sv
// One read port: write-through bypass with highest-port priority, plus stall flag.
module gp_rf_rdport
  import gp_rf_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int NWR     = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic [AW-1:0]     ra,
  input  logic [DW-1:0]     stored,
  input  logic              busy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  output logic [DW-1:0]     rd,
  output logic              rd_busy
);

  localparam logic Z0 = (ZERO_R0 != 0);

  logic hit;

  always_comb begin
    rd  = stored;
    hit = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wa[j*AW +: AW] == ra) && writable(32'(ra), Z0)) begin
        rd  = wd[j*DW +: DW];
        hit = 1'b1;
      end
    end
    if (!writable(32'(ra), Z0)) rd = '0;
    // A retiring producer this cycle supplies the data, so no stall.
    rd_busy = busy && !hit;
  end

endmodule

// File: rtl/gp_regfile_mp.sv
// Multi-port register file with write-through bypass and busy scoreboard.
// Optional write trace enabled by defining GRF_TRACE_EN.
module gp_regfile_mp
  import gp_rf_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  input  logic [NWR*32-1:0] wpc,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  output logic [AW:0]       busy_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam logic Z0 = (ZERO_R0 != 0);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_set;
  logic [DEPTH-1:0] busy_clr;
  logic [DEPTH-1:0] busy_next;
  logic [NWR-1:0]   wvalid;
  logic [NWR-1:0]   commit;
  logic [AW:0]      busy_inc;
  logic [AW:0]      busy_dec;

  always_comb begin
    wvalid   = '0;
    commit   = '0;
    busy_clr = '0;
    busy_set = '0;
    busy_dec = '0;
    for (int j = 0; j < NWR; j++) begin
      wvalid[j] = we[j] && writable(32'(wa[j*AW +: AW]), Z0);
      if (wvalid[j]) busy_clr[wa[j*AW +: AW]] = 1'b1;
    end
    // A write survives only if no higher port targets the same register.
    for (int j = 0; j < NWR; j++) begin
      commit[j] = wvalid[j];
      for (int k = j + 1; k < NWR; k++) begin
        if (wvalid[k] && (wa[k*AW +: AW] == wa[j*AW +: AW])) commit[j] = 1'b0;
      end
    end
    if (sb_set && writable(32'(sb_addr), Z0)) busy_set[sb_addr] = 1'b1;
    // Set after clear: a newly issued producer outranks the retiring one.
    busy_next = (busy & ~busy_clr) | busy_set;
    busy_inc  = (AW+1)'(|(busy_set & ~busy));
    for (int j = 0; j < NWR; j++) begin
      if (commit[j] && busy[wa[j*AW +: AW]] && !busy_set[wa[j*AW +: AW]])
        busy_dec = busy_dec + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= busy_cnt + busy_inc - busy_dec;
      for (int j = 0; j < NWR; j++) begin
        if (commit[j]) regs[wa[j*AW +: AW]] <= wd[j*DW +: DW];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    gp_rf_rdport #(
      .DW      (DW),
      .AW      (AW),
      .NWR     (NWR),
      .ZERO_R0 (ZERO_R0)
    ) u_port (
      .ra      (ra[i*AW +: AW]),
      .stored  (regs[ra[i*AW +: AW]]),
      .busy    (busy[ra[i*AW +: AW]]),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .rd      (rd[i*DW +: DW]),
      .rd_busy (rd_busy[i])
    );
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NWR; j++) begin
        if (commit[j])
          $display("%d@%h: $%d <= %h", $time, wpc[j*32 +: 32], wa[j*AW +: AW], wd[j*DW +: DW]);
      end
    end
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^wpc;
`endif

endmodule
